iob_acc_mc: RTL

//  Multi-channel load/accumulate unit: N_CH independent DATA_W accumulators behind one

---
 rtl/iob_acc_mc_pkg.sv | 13 +
 rtl/iob_acc_mc_alu.sv | 34 +++
 rtl/iob_acc_mc.sv | 127 ++++++++++++
 3 files changed

// File: rtl/iob_acc_mc_pkg.sv
// Shared types and helpers for the multi-channel accumulator.
package iob_acc_mc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_acc_mc_alu.sv
// Combinational add with carry/sign overflow detection and optional saturation.
module iob_acc_mc_alu #(
    parameter int DATA_W = 21,
    parameter bit SIGNED = 1'b0
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] incr,
    input  logic              sat,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] ext_acc;
    logic [DATA_W:0] ext_incr;
    logic [DATA_W:0] sum;

    always_comb begin
        ext_acc  = SIGNED ? {acc[DATA_W-1], acc}   : {1'b0, acc};
        ext_incr = SIGNED ? {incr[DATA_W-1], incr} : {1'b0, incr};
        sum      = ext_acc + ext_incr;
        ovf      = SIGNED ? ((acc[DATA_W-1] == incr[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]))
                          : sum[DATA_W];
        result   = sum[DATA_W-1:0];
        // A signed overflow always takes the direction of the operands' common sign.
        if (sat && ovf) begin
            if (SIGNED) result = acc[DATA_W-1] ? S_MIN : S_MAX;
            else        result = '1;
        end
    end

endmodule

// File: rtl/iob_acc_mc.sv
// N_CH independent accumulators behind one valid/ready update port,
// with sequenced clear-all and a registered read port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | updates accepted; clr_all_i starts a clear
//   ST_CLEAR | one channel reset per enabled cycle, updates blocked
module iob_acc_mc
    import iob_acc_mc_pkg::*;
#(
    parameter int                DATA_W  = 21,
    parameter int                N_CH    = 4,
    parameter bit                SIGNED  = 1'b0,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    localparam int               CH_W    = ch_width(N_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              sat_i,
    input  logic              clr_all_i,
    output logic              busy_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CH_W-1:0]   in_ch_i,
    input  logic              ld_i,
    input  logic [DATA_W-1:0] ld_val_i,
    input  logic [DATA_W-1:0] incr_i,
    input  logic [CH_W-1:0]   rd_ch_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [N_CH-1:0]   ovf_o
);

    state_t            state, state_nx;
    logic [CH_W-1:0]   clr_idx, clr_idx_nx;
    logic              clr_we;
    logic              accept;
    logic [DATA_W-1:0] acc [N_CH];
    logic [DATA_W-1:0] acc_cur;
    logic [DATA_W-1:0] rd_cur;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            clr_idx <= '0;
        end else if (cke_i) begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        clr_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_all_i) begin
                    state_nx   = ST_CLEAR;
                    clr_idx_nx = '0;
                end
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_idx == CH_W'(N_CH - 1)) begin
                    state_nx   = ST_IDLE;
                    clr_idx_nx = '0;
                end else begin
                    clr_idx_nx = clr_idx + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy_o     = (state == ST_CLEAR);
    assign in_ready_o = (state == ST_IDLE) && !clr_all_i;
    assign accept     = in_valid_i && in_ready_o && cke_i;

    // Mux loops rather than direct indexing so out-of-range channels read as 0.
    always_comb begin
        acc_cur = '0;
        rd_cur  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (in_ch_i == CH_W'(c)) acc_cur = acc[c];
            if (rd_ch_i == CH_W'(c)) rd_cur  = acc[c];
        end
    end

    iob_acc_mc_alu #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_alu (
        .acc    (acc_cur),
        .incr   (incr_i),
        .sat    (sat_i),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) acc[c] <= RST_VAL;
            ovf_o     <= '0;
            rd_data_o <= '0;
        end else if (cke_i) begin
            rd_data_o <= rd_cur;
            for (int c = 0; c < N_CH; c++) begin
                if (clr_we && (clr_idx == CH_W'(c))) begin
                    acc[c]   <= RST_VAL;
                    ovf_o[c] <= 1'b0;
                end else if (accept && (in_ch_i == CH_W'(c))) begin
                    if (ld_i) begin
                        acc[c]   <= ld_val_i;
                        ovf_o[c] <= 1'b0;
                    end else begin
                        acc[c] <= alu_result;
                        if (alu_ovf) ovf_o[c] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
